// File: rtl/wb_pkg.sv
// Shared constants and FSM encoding for the Wishbone memory responder.
package wb_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 30;
  localparam int unsigned WS_MAX = 7;
  localparam int unsigned CNT_W  = $clog2(WS_MAX + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/wb_sram.sv
// Single-port synchronous RAM with byte write enables and a registered read port.
// Kept separate so a technology macro can replace it without touching the bus logic.
module wb_sram #(
  parameter int unsigned DW    = 32,
  parameter int unsigned WORDS = 1024,
  parameter int unsigned IW    = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            we,
  input  logic [DW/8-1:0] sel,
  input  logic [IW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  localparam int unsigned NB = DW / 8;

  logic [DW-1:0] mem [WORDS];

  // Byte-masked write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (sel[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read word is captured only on a read operation and otherwise held.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 memory responder with a fixed number of wait states,
// out-of-range error reporting and abort on CYC drop.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned WS        = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic            o_wb_err,
  output logic [DW-1:0]   o_wb_data
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_data;
  logic [SW-1:0]    req_sel;

  logic             accept_c;
  logic             exec_c;
  logic             op_we_c;
  logic [AW-1:0]    op_addr_c;
  logic [DW-1:0]    op_data_c;
  logic [SW-1:0]    op_sel_c;
  logic             in_range_c;
  logic             ram_en_c;

  assign accept_c = i_wb_cyc & i_wb_stb & ~o_wb_stall;

  // With no wait states the operation runs straight off the bus; otherwise from the captured request.
  always_comb begin
    op_we_c   = req_we;
    op_addr_c = req_addr;
    op_data_c = req_data;
    op_sel_c  = req_sel;
    if (state == ST_IDLE) begin
      op_we_c   = i_wb_we;
      op_addr_c = i_wb_addr;
      op_data_c = i_wb_data;
      op_sel_c  = i_wb_sel;
    end
  end

  // Range check over the full address so high-bit aliases are rejected.
  assign in_range_c = ({1'b0, op_addr_c} < (AW + 1)'(MEM_WORDS));
  assign ram_en_c   = exec_c & in_range_c & ~i_reset;

  // Next-state logic: decide when the held request executes or is abandoned.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    exec_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (WS == 0) begin
            exec_c = 1'b1;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_W'(WS - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt == '0) begin
          exec_c   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register plus registered stall and completion strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      o_wb_stall <= 1'b0;
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      o_wb_stall <= (state_nx == ST_WAIT);
      o_wb_ack   <= exec_c & in_range_c;
      o_wb_err   <= exec_c & ~in_range_c;
    end
  end

  // Capture the request on acceptance for use after the wait states.
  always_ff @(posedge i_clk) begin
    if (accept_c) begin
      req_we   <= i_wb_we;
      req_addr <= i_wb_addr;
      req_data <= i_wb_data;
      req_sel  <= i_wb_sel;
    end
  end

  wb_sram #(
    .DW    (DW),
    .WORDS (MEM_WORDS),
    .IW    (IW)
  ) u_sram (
    .clk   (i_clk),
    .reset (i_reset),
    .en    (ram_en_c),
    .we    (op_we_c),
    .sel   (op_sel_c),
    .addr  (op_addr_c[IW-1:0]),
    .wdata (op_data_c),
    .rdata (o_wb_data)
  );

endmodule

// File: tb/tb_wb_mem_slave.sv
// Randomized bench for wb_mem_slave: one instance with no wait states, one with three.
module tb_wb_mem_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 30;
  localparam int unsigned MW = 1024;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    sel;
  } req_t;

  typedef struct {
    int          due;
    bit          err;
    bit          rd;
    logic [31:0] data;
    logic [31:0] mask;
  } cpl_t;

  logic          clk = 1'b0;
  logic          rst   [2];
  logic          cyc   [2];
  logic          stb   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdat  [2];
  logic [3:0]    sel   [2];
  logic          stall [2];
  logic          ack   [2];
  logic          err   [2];
  logic [DW-1:0] rdat  [2];

  // Reference state: memory image with per-byte known mask, and last read word.
  logic [31:0] mem_m     [2][MW];
  logic [31:0] known     [2][MW];
  logic [31:0] last_rd   [2];
  logic [31:0] last_kn   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_mem_slave #(.DW(DW), .AW(AW), .MEM_WORDS(MW), .WS(0)) u_ws0 (
    .i_clk(clk), .i_reset(rst[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]),
    .i_wb_we(we[0]), .i_wb_addr(addr[0]), .i_wb_data(wdat[0]), .i_wb_sel(sel[0]),
    .o_wb_stall(stall[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wb_data(rdat[0])
  );

  wb_mem_slave #(.DW(DW), .AW(AW), .MEM_WORDS(MW), .WS(3)) u_ws3 (
    .i_clk(clk), .i_reset(rst[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]),
    .i_wb_we(we[1]), .i_wb_addr(addr[1]), .i_wb_data(wdat[1]), .i_wb_sel(sel[1]),
    .o_wb_stall(stall[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wb_data(rdat[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk(input bit w, input int a, input logic [31:0] dt, input logic [3:0] s);
    req_t r;
    r.we = w; r.addr = AW'(a); r.data = dt; r.sel = s;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   k;
    k      = $urandom_range(0, 9);
    r.we   = 1'($urandom_range(0, 1));
    r.data = $urandom;
    r.sel  = 4'($urandom);
    if (k <= 5)      r.addr = AW'($urandom_range(0, 15));
    else if (k == 6) r.addr = AW'(MW - 1 - $urandom_range(0, 3));
    else if (k == 7) r.addr = AW'(MW + $urandom_range(0, 7));
    else if (k == 8) r.addr = AW'(32'h2000_0000 + $urandom_range(0, 15));
    else             r.addr = AW'($urandom) | AW'(MW);
    return r;
  endfunction

  // Apply one request to the reference image and return its expected completion.
  task automatic model_op(input int d, input req_t r, output cpl_t c);
    int a;
    c.err  = !(r.addr < AW'(MW));
    c.rd   = !r.we;
    c.due  = 0;
    if (!c.err) begin
      a = int'(r.addr);
      if (r.we) begin
        for (int i = 0; i < 4; i++) begin
          if (r.sel[i]) begin
            mem_m[d][a][i*8 +: 8] = r.data[i*8 +: 8];
            known[d][a][i*8 +: 8] = 8'hFF;
          end
        end
      end else begin
        last_rd[d] = mem_m[d][a];
        last_kn[d] = known[d][a];
      end
    end
    c.data = last_rd[d];
    c.mask = last_kn[d];
  endtask

  // Cycle-stepped driver: issues directed then random requests, checking stall and completions.
  task automatic run(input int d, input req_t dq[$], input int n_rand, input bit noisy);
    int   ws, e, last_a, left;
    bit   stall_exp, have, s, c;
    req_t r;
    cpl_t cp;
    cpl_t pend[$];
    string pfx;
    ws = (d == 0) ? 0 : 3;
    pfx = $sformatf("ws%0d", ws);
    e = 0; last_a = -1000; left = n_rand;
    stall_exp = 1'b0; have = 1'b0;
    r = mk(1'b0, 0, 32'h0, 4'h0);
    for (int k = 0; k < 5000; k++) begin
      if (!have) begin
        if (dq.size() > 0) begin
          r = dq.pop_front(); have = 1'b1;
        end else if (left > 0) begin
          r = rand_req(); have = 1'b1; left--;
        end
      end
      if (!have && pend.size() == 0) break;
      s = have && (!noisy || $urandom_range(0, 3) != 0);
      c = 1'b1;
      if (noisy && !stall_exp && $urandom_range(0, 7) == 0) c = 1'b0;
      cyc[d] = c; stb[d] = s; we[d] = r.we; addr[d] = r.addr; wdat[d] = r.data; sel[d] = r.sel;
      if (c && s && !stall_exp) begin
        model_op(d, r, cp);
        cp.due = e + ws;
        pend.push_back(cp);
        last_a = e;
        have = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      stall_exp = (e - last_a) < ws;
      check({pfx, " stall"}, 32'(stall[d]), 32'(stall_exp));
      if (pend.size() > 0 && pend[0].due == e) begin
        cp = pend.pop_front();
        check({pfx, " ack"}, 32'(ack[d]), 32'(!cp.err));
        check({pfx, " err"}, 32'(err[d]), 32'(cp.err));
        if (cp.rd || cp.err) check({pfx, " rdata"}, rdat[d] & cp.mask, cp.data & cp.mask);
      end else begin
        check({pfx, " idle ack"}, 32'(ack[d]), 32'h0);
        check({pfx, " idle err"}, 32'(err[d]), 32'h0);
      end
      e++;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    check({pfx, " drained"}, 32'(pend.size()) + 32'(have), 32'h0);
  endtask

  // Drop CYC two cycles into a three-wait-state write: no completion, no write.
  task automatic abort_test(input int d);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; addr[d] = AW'(7); wdat[d] = 32'h0BAD_0BAD; sel[d] = 4'hF;
    @(posedge clk); @(negedge clk);
    stb[d] = 1'b0;
    check("abort stall A+1", 32'(stall[d]), 32'h1);
    @(posedge clk); @(negedge clk);
    check("abort stall A+2", 32'(stall[d]), 32'h1);
    cyc[d] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("abort stall", 32'(stall[d]), 32'h0);
      check("abort ack", 32'(ack[d]), 32'h0);
      check("abort err", 32'(err[d]), 32'h0);
    end
  endtask

  // Reset while a write waits: the write and its completion are discarded.
  task automatic reset_test(input int d);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; addr[d] = AW'(7); wdat[d] = 32'h5A5A_5A5A; sel[d] = 4'hF;
    @(posedge clk); @(negedge clk);
    stb[d] = 1'b0;
    rst[d] = 1'b1;
    check("rst pre stall", 32'(stall[d]), 32'h1);
    @(posedge clk); @(negedge clk);
    rst[d] = 1'b0;
    last_rd[d] = 32'h0; last_kn[d] = 32'hFFFF_FFFF;
    check("rst stall", 32'(stall[d]), 32'h0);
    check("rst ack", 32'(ack[d]), 32'h0);
    check("rst err", 32'(err[d]), 32'h0);
    check("rst rdata", rdat[d], 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("post-rst ack", 32'(ack[d]), 32'h0);
      check("post-rst err", 32'(err[d]), 32'h0);
    end
    cyc[d] = 1'b0;
  endtask

  initial begin
    req_t q[$];
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      addr[d] = '0; wdat[d] = '0; sel[d] = '0;
      last_rd[d] = 32'h0; last_kn[d] = 32'hFFFF_FFFF;
      for (int a = 0; a < int'(MW); a++) begin
        mem_m[d][a] = 32'h0; known[d][a] = 32'h0;
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset stall %0d", d), 32'(stall[d]), 32'h0);
      check($sformatf("reset ack %0d", d), 32'(ack[d]), 32'h0);
      check($sformatf("reset err %0d", d), 32'(err[d]), 32'h0);
      check($sformatf("reset rdata %0d", d), rdat[d], 32'h0);
    end

    // No wait states: back-to-back write/read, byte mask, out-of-range, neighbour intact.
    q = {};
    q.push_back(mk(1'b1, 1023, 32'hCAFE_F00D, 4'hF));
    q.push_back(mk(1'b1, 5,    32'hDEAD_BEEF, 4'hF));
    q.push_back(mk(1'b0, 5,    32'h0,         4'h0));
    q.push_back(mk(1'b1, 5,    32'h1122_3344, 4'b0101));
    q.push_back(mk(1'b0, 5,    32'h0,         4'h0));
    q.push_back(mk(1'b1, 1024, 32'h5555_5555, 4'hF));
    q.push_back(mk(1'b0, 1024, 32'h0,         4'h0));
    q.push_back(mk(1'b0, 1023, 32'h0,         4'h0));
    run(0, q, 0, 1'b0);
    q = {};
    run(0, q, 400, 1'b1);

    // Three wait states: paced reads held on STB, then abort, reset, and readback.
    q = {};
    q.push_back(mk(1'b1, 0, 32'h0102_0304, 4'hF));
    q.push_back(mk(1'b1, 7, 32'h7777_7777, 4'hF));
    q.push_back(mk(1'b0, 0, 32'h0,         4'h0));
    q.push_back(mk(1'b0, 0, 32'h0,         4'h0));
    run(1, q, 0, 1'b0);
    abort_test(1);
    reset_test(1);
    q = {};
    q.push_back(mk(1'b0, 7, 32'h0, 4'h0));
    q.push_back(mk(1'b1, 1030, 32'h1, 4'hF));
    q.push_back(mk(1'b0, 1023, 32'h0, 4'h0));
    run(1, q, 0, 1'b0);
    q = {};
    run(1, q, 250, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
# wb_mem_slave

Pipelined Wishbone B4 responder. It serves single-word reads and byte-masked writes to an on-chip memory array, with a programmable number of wait states. It is the far end of the bus driven by the team's Wishbone bus master, and the default target for bring-up and for bridge testing. It reports out-of-range accesses with an error instead of an acknowledge, and abandons a pending request when the master drops CYC.

## Interface
- DW, 32: data width; must be a multiple of 8.
- AW, 30: word-address width.
- MEM_WORDS, 1024: number of implemented words; valid addresses are 0..MEM_WORDS-1.
- WS, 0: wait states per request, range 0..7.

Ports:
- i_clk  in  1  single clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_cyc  in  1  bus cycle in progress.
- i_wb_stb  in  1  request strobe; ignored unless i_wb_cyc=1.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  AW  word address.
- i_wb_data  in  DW  write data.
- i_wb_sel  in  DW/8  byte enables for writes.
- o_wb_stall  out  1  request cannot be accepted this cycle.
- o_wb_ack  out  1  one-cycle successful completion.
- o_wb_err  out  1  one-cycle failed completion (address out of range).
- o_wb_data  out  DW  read data; valid while o_wb_ack=1.

## Operation
- Accept condition: i_wb_cyc & i_wb_stb & !o_wb_stall, sampled at edge A.
- On accept, the block captures we, addr, data and sel into request registers.
- FSM states:
  - IDLE: o_wb_stall=0.
  - WAIT: o_wb_stall=1; holds down-counter cnt (3 bits).
- Transitions:
  - IDLE→IDLE: accept with WS=0. The operation executes at edge A.
  - IDLE→WAIT: accept with WS>0. cnt<=WS-1 and o_wb_stall<=1.
  - WAIT, cnt≠0: cnt decrements.
  - WAIT, cnt=0: the operation executes at that edge, o_wb_stall<=0, and the FSM returns to IDLE.
  - WAIT, i_wb_cyc=0 (abort, any cnt): return to IDLE. No memory write, no ack, no err; o_wb_stall<=0.
- Operation edge E = A+WS.
  - In range (addr < MEM_WORDS, compared over all AW bits):
    - Write: bytes with sel[i]=1 are updated.
    - Read: the full word is latched into o_wb_data regardless of sel.
    - o_wb_ack<=1.
  - Out of range:
    - No memory access; o_wb_data holds its previous value.
    - o_wb_err<=1.
- o_wb_ack and o_wb_err are high for exactly one cycle per completed request and are never both high.
- Exactly one ack or err is returned per accepted, non-aborted request, in acceptance order.
- Requests are strictly in order; at most one is outstanding when WS>0.
- STB with CYC=0 is ignored. Behaviour when CYC drops during the ack cycle is the master's responsibility; the ack is still issued.
- Memory contents are not reset.

## Timing
- Reset values: o_wb_stall=0, o_wb_ack=0, o_wb_err=0, o_wb_data=0, state=IDLE, cnt=0.
- Reset mid-request: the request is discarded, with no write and no completion.
- WS=0:
  - Zero stall; a request can be accepted every cycle.
  - Ack/err is in the cycle after A (latency 1).
- WS=n>0:
  - o_wb_stall is high in cycles A+1..A+n.
  - Ack/err is in cycle A+n+1.
  - A new request may be accepted in that same ack cycle, giving throughput of 1 request per n+1 cycles.
- Read-after-write: a write executed at edge E is visible to any read executed at an edge after E, including a back-to-back read with WS=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/header wb_pkg:
  - FSM state encoding (IDLE, WAIT).
  - Default DW/AW constants.
  - WS_MAX=7.
- Sub-module wb_sram:
  - Synchronous byte-write RAM: we, sel, addr, wdata, rdata.
  - Read data registered at the operation edge.
  - Isolated so it can be swapped for a technology RAM.
- Top level: FSM, request registers, range check, completion flags.

## Test plan
1. WS=0: write 0xDEADBEEF to addr 5 with sel=4'hF, then a back-to-back read of addr 5 → acks in consecutive cycles; read ack carries 0xDEADBEEF; o_wb_stall never asserted.
2. Byte mask: addr 5 holds 0xDEADBEEF; write 0x11223344 with sel=4'b0101 → subsequent read returns 0xDE22BE44.
3. WS=3: read of addr 0 accepted at cycle 10 → stall high in cycles 11–13, ack in cycle 14; a second read held on STB is accepted at edge 14 and acked in cycle 18.
4. Out of range (MEM_WORDS=1024): write to addr 1024, then read of 1024 → o_wb_err pulses once for each, no ack; a read of addr 1023 shows the old value unchanged.
5. Abort, WS=5: write accepted, CYC dropped 2 cycles later → no ack/err, stall low on the next cycle, memory unchanged; a new request is accepted normally afterwards.
6. Reset in WAIT, WS=4: assert i_reset for 1 cycle after accept → all outputs 0, no completion, write not performed.
